// File: rtl/divresult_bcd.sv
// Sequential binary-to-BCD converter for the divider's quotient/remainder pair (double dabble, one bit per clock).
// Optional leading-zero blanking outputs are enabled by defining DIVRESULT_BLANK_EN.

module divresult_bcd_lane #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] acc,
    input  logic [WIDTH-1:0]    bin,
    output logic [4*DIGITS-1:0] acc_nxt,
    output logic [WIDTH-1:0]    bin_nxt
);
    logic [4*DIGITS-1:0] adj;

    // Each digit is corrected on its own; a digit is at most 9 here, so +3 never carries out.
    always_comb begin
        adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
        {acc_nxt, bin_nxt} = {adj[4*DIGITS-2:0], bin, 1'b0};
    end
endmodule

module divresult_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    q_in,
    input  logic [WIDTH-1:0]    r_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] q_bcd,
    output logic [4*DIGITS-1:0] r_bcd,
`ifdef DIVRESULT_BLANK_EN
    output logic [DIGITS-1:0]   q_blank,
    output logic [DIGITS-1:0]   r_blank,
`endif
    output logic                busy
);
    localparam int LANES = 2;
    localparam int BW    = 4*DIGITS;
    localparam int CW    = $clog2(WIDTH+1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                         state, state_nxt;
    logic [LANES-1:0][WIDTH-1:0]    bin, bin_nxt;
    logic [LANES-1:0][BW-1:0]       acc, acc_nxt;
    logic [CW-1:0]                  cnt;
    logic                           last_step;

    // Lane 0 converts the quotient, lane 1 the remainder.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        divresult_bcd_lane #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_lane (
            .acc     (acc[l]),
            .bin     (bin[l]),
            .acc_nxt (acc_nxt[l]),
            .bin_nxt (bin_nxt[l])
        );
    end

    assign last_step = (cnt == CW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SHIFT;
            SHIFT:   if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

`ifdef DIVRESULT_BLANK_EN
    // Bit k marks digit k as a suppressible leading zero; digit 0 always shows.
    function automatic logic [DIGITS-1:0] lead_zero(input logic [BW-1:0] v);
        logic z;
        lead_zero = '0;
        z = 1'b1;
        for (int k = DIGITS-1; k >= 1; k--) begin
            z = z & (v[4*k +: 4] == 4'd0);
            lead_zero[k] = z;
        end
    endfunction
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin   <= '0;
            acc   <= '0;
            cnt   <= '0;
            q_bcd <= '0;
            r_bcd <= '0;
`ifdef DIVRESULT_BLANK_EN
            q_blank <= '0;
            r_blank <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    bin[0] <= q_in;
                    bin[1] <= r_in;
                    acc    <= '0;
                    cnt    <= CW'(WIDTH);
                end
                SHIFT: begin
                    bin <= bin_nxt;
                    acc <= acc_nxt;
                    cnt <= cnt - CW'(1);
                    // Result registers only move on completion so they hold until the next DONE.
                    if (last_step) begin
                        q_bcd <= acc_nxt[0];
                        r_bcd <= acc_nxt[1];
`ifdef DIVRESULT_BLANK_EN
                        q_blank <= lead_zero(acc_nxt[0]);
                        r_blank <= lead_zero(acc_nxt[1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == SHIFT);
    assign out_valid = (state == DONE);
endmodule

// File: tb/tb_divresult_bcd.sv
// Scoreboard bench for divresult_bcd: directed pairs queue expected BCD, a negedge monitor checks on each output handshake.

module tb_divresult_bcd;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  q_in, r_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] q_bcd, r_bcd;
    logic        busy;
`ifdef DIVRESULT_BLANK_EN
    logic [2:0]  q_blank, r_blank;
`endif

    logic fixed_rdy, rand_rdy, rnd_bit;
    assign out_ready = rand_rdy ? rnd_bit : fixed_rdy;

    typedef struct {
        logic [11:0] eq;
        logic [11:0] er;
        logic [2:0]  bq;
        logic [2:0]  br;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    divresult_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_in      (q_in),
        .r_in      (r_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd),
`ifdef DIVRESULT_BLANK_EN
        .q_blank   (q_blank),
        .r_blank   (r_blank),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Decimal reference: digits by division, independent of shift-add-3.
    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] d0, d1, d2;
        d0 = 4'(v % 10);
        d1 = 4'((v / 10) % 10);
        d2 = 4'((v / 100) % 10);
        return {d2, d1, d0};
    endfunction

    function automatic logic [2:0] to_blank(input int v);
        return {v < 100, v < 10, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    // Monitor: compare on handshake, check hold-under-backpressure and the cycle after each handshake.
    logic        hs_pend = 1'b0, prev_valid = 1'b0;
    logic [11:0] prev_q, prev_r;
    always @(negedge clk) begin
        if (reset) begin
            if (hs_pend) begin
                checks++;
                if (out_valid || !in_ready || busy) begin
                    errors++;
                    $display("FAIL post_handshake out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy);
                end
            end else if (prev_valid) begin
                checks++;
                if (!out_valid || q_bcd !== prev_q || r_bcd !== prev_r) begin
                    errors++;
                    $display("FAIL hold out_valid=%b q=%h r=%h exp 1 q=%h r=%h", out_valid, q_bcd, r_bcd, prev_q, prev_r);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output q=%h r=%h", q_bcd, r_bcd);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (q_bcd !== e.eq || r_bcd !== e.er) begin
                        errors++;
                        $display("FAIL result q=%h r=%h exp q=%h r=%h", q_bcd, r_bcd, e.eq, e.er);
                    end
`ifdef DIVRESULT_BLANK_EN
                    checks++;
                    if (q_blank !== e.bq || r_blank !== e.br) begin
                        errors++;
                        $display("FAIL blank q=%b r=%b exp q=%b r=%b", q_blank, r_blank, e.bq, e.br);
                    end
`endif
                end
            end
            hs_pend    = out_valid && out_ready;
            prev_valid = out_valid && !out_ready;
            prev_q     = q_bcd;
            prev_r     = r_bcd;
        end else begin
            hs_pend    = 1'b0;
            prev_valid = 1'b0;
        end
    end

    // Present a pair until accepted; returns 1 ns after the capture edge.
    task automatic send(input int q, input int r, input logic [11:0] eq, input logic [11:0] er,
                        input bit hold, input bit track);
        int n;
        exp_t e;
        n = 0;
        in_valid = 1'b1;
        q_in = q[7:0];
        r_in = r[7:0];
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%b exp 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        if (track) begin
            e.eq = eq; e.er = er; e.bq = to_blank(q); e.br = to_blank(r);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d exp 0", sb.size());
        end
    endtask

    initial begin
        int edges, busy_n, n;
        reset = 1'b0; in_valid = 1'b0; q_in = '0; r_in = '0;
        fixed_rdy = 1'b1; rand_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_q_bcd", q_bcd, 0);
        chk("rst_r_bcd", r_bcd, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Max value; edges counted inclusively from the capture edge.
        send(255, 7, 12'h255, 12'h007, 0, 1);
        edges = 1; busy_n = 0;
        while (!out_valid && edges < 40) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            edges++;
        end
        chk("busy_cycles", busy_n, 8);
        chk("latency_edges", edges, 9);
        drain(50);

        send(0, 0, 12'h000, 12'h000, 0, 1);
        drain(50);

        // Backpressure for 20 cycles; the monitor checks hold every cycle.
        fixed_rdy = 1'b0;
        send(100, 99, 12'h100, 12'h099, 0, 1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (20) @(posedge clk);
        #1;
        chk("bp_out_valid", out_valid, 1);
        chk("bp_q_bcd", q_bcd, 12'h100);
        chk("bp_r_bcd", r_bcd, 12'h099);
        fixed_rdy = 1'b1;
        drain(50);

        // Back-to-back with in_valid held high.
        send(37, 5, 12'h037, 12'h005, 1, 1);
        send(200, 19, 12'h200, 12'h019, 0, 1);
        drain(50);

        // Abort on the 4th SHIFT cycle.
        send(123, 0, 12'h123, 12'h000, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_q_bcd", q_bcd, 0);
        chk("abort_r_bcd", r_bcd, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        send(42, 1, 12'h042, 12'h001, 0, 1);
        drain(50);

        // Full sweep with random consumer stalls.
        rand_rdy = 1'b1;
        for (int q = 0; q < 256; q++)
            send(q, 255 - q, to_bcd(q), to_bcd(255 - q), 1, 1);
        in_valid = 1'b0;
        drain(2000);
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
